// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package mips_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int IMEM_DEPTH  = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      CSUM  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer with running XOR checksum.
module imem_word_packer
   import mips_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   byte_en,
   input  logic [7:0]             byte_in,
   output logic [INSTR_WIDTH-1:0] word_next,
   output logic [7:0]             csum,
   output logic                   word_full
);

   localparam int NUM_BYTES = INSTR_WIDTH / 8;

   logic [INSTR_WIDTH-1:0] word_reg;
   logic [1:0]             byte_cnt_reg;
   logic [7:0]             csum_reg;

   // word_next already contains the byte being accepted, so the loader can
   // register the complete word on the same edge as the final handshake.
   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         if (gi == 0) begin : g_low
            assign word_next[7:0] = byte_in;
         end else begin : g_shift
            assign word_next[8*gi +: 8] = word_reg[8*(gi-1) +: 8];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word_reg     <= '0;
         byte_cnt_reg <= 2'd0;
         csum_reg     <= 8'd0;
      end else if (byte_en) begin
         word_reg     <= word_next;
         byte_cnt_reg <= byte_cnt_reg + 2'd1;
         csum_reg     <= csum_reg ^ byte_in;
      end
   end

   assign csum      = csum_reg;
   assign word_full = byte_en && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into instruction memory, verifies an XOR
// checksum, and releases the core from reset only after a clean load.
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH),
   parameter int DATA_WIDTH = INSTR_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len_words,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int ADDR_PAD = 32 - ADDR_WIDTH - 2;

   loader_state_e         state_reg, state_next;
   logic [ADDR_WIDTH-1:0] word_idx_reg, word_idx_next;
   logic [ADDR_WIDTH:0]   len_reg, len_next;
   logic                  s_ready_reg, s_ready_next;
   logic                  mem_we_reg, mem_we_next;
   logic [31:0]           mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
   logic                  cpu_rst_reg, cpu_rst_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;
   logic                  error_reg, error_next;

   logic                  hs, len_legal, last_word;
   logic                  pk_clear, pk_byte_en, pk_word_full;
   logic [DATA_WIDTH-1:0] pk_word;
   logic [7:0]            pk_csum;

   assign hs         = s_valid && s_ready_reg;
   assign pk_byte_en = hs && (state_reg == RECV);
   // Legal lengths are 1..2^ADDR_WIDTH: with the top bit set only the exact
   // power of two is allowed.
   assign len_legal  = (len_words != '0) &&
                       (!len_words[ADDR_WIDTH] || (len_words[ADDR_WIDTH-1:0] == '0));
   assign last_word  = ({1'b0, word_idx_reg} == (len_reg - (ADDR_WIDTH+1)'(1)));

   imem_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pk_clear),
      .byte_en   (pk_byte_en),
      .byte_in   (s_data),
      .word_next (pk_word),
      .csum      (pk_csum),
      .word_full (pk_word_full)
   );

   always_comb begin
      state_next     = state_reg;
      word_idx_next  = word_idx_reg;
      len_next       = len_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      cpu_rst_next   = cpu_rst_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      error_next     = error_reg;
      pk_clear       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               cpu_rst_next = 1'b1;
               if (len_legal) begin
                  len_next      = len_words;
                  word_idx_next = '0;
                  pk_clear      = 1'b1;
                  error_next    = 1'b0;
                  busy_next     = 1'b1;
                  state_next    = RECV;
               end else begin
                  done_next  = 1'b1;
                  error_next = 1'b1;
               end
            end
         end
         RECV: begin
            if (pk_word_full) begin
               mem_we_next    = 1'b1;
               mem_addr_next  = {{ADDR_PAD{1'b0}}, word_idx_reg, 2'b00};
               mem_wdata_next = pk_word;
               state_next     = WRITE;
            end
         end
         WRITE: begin
            if (last_word) begin
               state_next = CSUM;
            end else begin
               word_idx_next = word_idx_reg + ADDR_WIDTH'(1);
               state_next    = RECV;
            end
         end
         CSUM: begin
            if (hs) begin
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
               if (s_data == pk_csum) begin
                  error_next   = 1'b0;
                  cpu_rst_next = 1'b0;
               end else begin
                  error_next   = 1'b1;
                  cpu_rst_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      s_ready_next = (state_next == RECV) || (state_next == CSUM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         word_idx_reg  <= '0;
         len_reg       <= '0;
         s_ready_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         cpu_rst_reg   <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         word_idx_reg  <= word_idx_next;
         len_reg       <= len_next;
         s_ready_reg   <= s_ready_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         cpu_rst_reg   <= cpu_rst_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
      end
   end

   assign s_ready   = s_ready_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign cpu_rst   = cpu_rst_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign error     = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done results are
// queued as stimulus is driven and popped as the loader produces them.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  len_words;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        error;

   imem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len_words (len_words),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wq_addr [$];
   logic [31:0] wq_data [$];
   logic        dq_err  [$];
   logic        dq_cpu  [$];

   logic [7:0]  stream [0:1023];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   logic        sready_seen = 1'b0;
   logic        prev_done = 1'b0;
   logic [31:0] last_addr = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (s_ready) sready_seen = 1'b1;
      if (prev_done) chk("done_width", 32'(done), 32'd0);
      prev_done = done;
      if (mem_we) begin
         wr_cnt++;
         last_addr = mem_addr;
         $display("WR   addr=%h data=%h", mem_addr, mem_wdata);
         if (wq_addr.size() == 0) begin
            chk("unexp_we", 32'd1, 32'd0);
         end else begin
            chk("wr_addr", mem_addr, wq_addr.pop_front());
            chk("wr_data", mem_wdata, wq_data.pop_front());
         end
      end
      if (done) begin
         done_cnt++;
         $display("DONE error=%b cpu_rst=%b", error, cpu_rst);
         if (dq_err.size() == 0) begin
            chk("unexp_done", 32'd1, 32'd0);
         end else begin
            chk("done_error", 32'(error), 32'(dq_err.pop_front()));
            chk("done_cpu_rst", 32'(cpu_rst), 32'(dq_cpu.pop_front()));
            chk("done_busy", 32'(busy), 32'd0);
         end
      end
   end

   task automatic check_reset();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
   endtask

   // All drive tasks begin and end 1 time unit after a rising edge.
   task automatic do_start(input logic [8:0] len);
      start     = 1'b1;
      len_words = len;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_s_ready", 32'(s_ready), 32'd1);
      chk("start_error", 32'(error), 32'd0);
      chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      logic hs;
      int   n;
      int   gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      forever begin
         hs = s_ready;
         @(posedge clk); #1;
         if (hs) break;
         n++;
         if (n > 200) begin
            chk("hs_timeout", 32'd0, 32'd1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_load(input int len, input int max_gap, input bit bad_csum, input int extra_start_at);
      logic [7:0] cs;
      int d0;
      cs = 8'd0;
      for (int w = 0; w < len; w++) begin
         wq_addr.push_back(32'(w * 4));
         wq_data.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
         for (int k = 0; k < 4; k++) cs ^= stream[4*w+k];
      end
      dq_err.push_back(bad_csum);
      dq_cpu.push_back(bad_csum);
      d0 = done_cnt;
      do_start(9'(len));
      for (int i = 0; i < 4*len; i++) begin
         if (i == extra_start_at) begin
            start     = 1'b1;
            len_words = 9'd1;
         end
         send_byte(stream[i], max_gap);
         start = 1'b0;
         if (i % 4 == 3) begin
            chk("we_latency", 32'(mem_we), 32'd1);
            chk("write_s_ready", 32'(s_ready), 32'd0);
         end
      end
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, max_gap);
      chk("done_latency", 32'(done), 32'd1);
      wait_done(d0);
   endtask

   task automatic bad_start(input logic [8:0] len);
      int w0;
      w0 = wr_cnt;
      sready_seen = 1'b0;
      dq_err.push_back(1'b1);
      dq_cpu.push_back(1'b1);
      start     = 1'b1;
      len_words = len;
      @(posedge clk); #1;
      start = 1'b0;
      chk("bad_done", 32'(done), 32'd1);
      repeat (5) begin @(posedge clk); #1; end
      chk("bad_no_we", 32'(wr_cnt), 32'(w0));
      chk("bad_no_s_ready", 32'(sready_seen), 32'd0);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_error_sticky", 32'(error), 32'd1);
   endtask

   initial begin
      int w0;
      logic [7:0] vec [0:7];
      rst = 1'b1; start = 1'b0; len_words = '0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      @(posedge clk); #1;

      vec[0] = 8'h20; vec[1] = 8'h09; vec[2] = 8'h00; vec[3] = 8'h05;
      vec[4] = 8'h20; vec[5] = 8'h0A; vec[6] = 8'h00; vec[7] = 8'h0A;
      for (int i = 0; i < 8; i++) stream[i] = vec[i];
      // Independent cross-check of the worked example's expected words.
      chk("vec_word0", {stream[0], stream[1], stream[2], stream[3]}, 32'h20090005);

      run_load(2, 0, 1'b0, -1);
      chk("clean_cpu_rst", 32'(cpu_rst), 32'd0);
      run_load(2, 0, 1'b1, -1);
      repeat (3) begin @(posedge clk); #1; end
      chk("bad_csum_error_sticky", 32'(error), 32'd1);
      chk("bad_csum_cpu_rst", 32'(cpu_rst), 32'd1);

      for (int i = 0; i < 12; i++) stream[i] = 8'($urandom);
      w0 = wr_cnt;
      run_load(3, 0, 1'b0, -1);
      run_load(3, 4, 1'b0, -1);
      chk("gap_write_count", 32'(wr_cnt - w0), 32'd6);

      bad_start(9'd0);
      bad_start(9'd257);

      for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
      wq_addr.push_back(32'd0);
      wq_data.push_back({stream[0], stream[1], stream[2], stream[3]});
      w0 = wr_cnt;
      do_start(9'd2);
      for (int i = 0; i < 6; i++) send_byte(stream[i], 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset();
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_one_write", 32'(wr_cnt - w0), 32'd1);
      chk("rst_queue_empty", 32'(wq_addr.size()), 32'd0);
      run_load(1, 0, 1'b0, -1);

      for (int i = 0; i < 1024; i++) stream[i] = 8'($urandom);
      w0 = wr_cnt;
      run_load(256, 0, 1'b0, 41);
      chk("full_write_count", 32'(wr_cnt - w0), 32'd256);
      chk("full_last_addr", last_addr, 32'h3FC);
      chk("full_error", 32'(error), 32'd0);
      chk("full_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("final_queue_empty", 32'(wq_addr.size() + dq_err.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the instruction memory. It receives a byte stream over a valid/ready handshake and packs each four bytes big-endian into a 32-bit instruction. Each instruction is written into the instruction memory at consecutive word-aligned byte addresses. A trailing XOR checksum byte is verified, and the processor core is held in reset until a load completes cleanly. The block sits between the host/debug link and the instruction memory's write port, and drives the core's reset.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: word-index width; memory depth is 2^ADDR_WIDTH words (256).
- `DATA_WIDTH`, default 32: instruction width, fixed at 32.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load; honoured only in IDLE.
- `len_words` in ADDR_WIDTH+1: number of instructions to load; legal range 1..2^ADDR_WIDTH.
- `s_valid` in 1: input byte valid.
- `s_data` in 8: input byte.
- `s_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction-memory write strobe.
- `mem_addr` out 32: byte address, word-aligned; bits [1:0] are always 0 and the word index is `mem_addr[ADDR_WIDTH+1:2]`.
- `mem_wdata` out 32: instruction word.
- `cpu_rst` out 1: active-high reset to the core.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse marking the end of a load attempt.
- `error` out 1: last load failed; sticky until the next accepted `start`.

## Operation

- Reset values:
  - `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_rst`=1, `busy`=0, `done`=0, `error`=0.
  - State = IDLE; internal word counter, byte counter and checksum = 0.
- IDLE:
  - `start` with legal `len_words`: latch `len_words`, clear the counters and checksum, clear `error`, set `cpu_rst`=1 and `busy`=1, go to RECV.
  - `start` with `len_words`=0 or >2^ADDR_WIDTH: stay in IDLE, pulse `done`, set `error`=1, set `cpu_rst`=1, perform no writes.
- RECV (`s_ready`=1):
  - On each handshake, shift `s_data` into the word buffer; the first byte lands in [31:24].
  - XOR the byte into the checksum and increment the byte counter.
  - On the 4th byte, go to WRITE.
- WRITE (`s_ready`=0):
  - `mem_we`=1 for exactly one cycle, with `mem_addr`=word_idx<<2 and `mem_wdata`=packed word.
  - If word_idx == len−1, go to CSUM; otherwise increment word_idx and go to RECV.
- CSUM (`s_ready`=1):
  - Accept one byte and compare it with the running checksum, then return to IDLE.
  - `done` pulses and `busy` drops.
  - On a match, `error`=0 and `cpu_rst`=0. On a mismatch, `error`=1 and `cpu_rst` stays 1.
- `start` outside IDLE is ignored.
- Words are never skipped or reordered. The address never wraps; the last legal address is (2^ADDR_WIDTH−1)<<2.
- `rst` mid-load aborts immediately with reset values. A write already in flight is not repeated, and no partial word is written.

## Timing

- All outputs are registered.
- `s_ready` is a function of state only: high in RECV/CSUM, low elsewhere. It does not depend on `s_valid`.
- A byte is consumed only on a cycle where `s_valid` and `s_ready` are both 1. `s_data` is sampled at that edge.
- Minimum throughput is 5 cycles per word (4 accept cycles + 1 write cycle). Stalls on `s_valid` extend RECV indefinitely with no timeout.
- Accepted `start` at edge N gives `busy`=1 and `s_ready`=1 in cycle N+1.
- The 4th-byte handshake at edge N gives `mem_we`=1 in cycle N+1 only.
- The checksum handshake at edge N gives `done`=1 in cycle N+1, with `busy`=0, `error` and `cpu_rst` updated in that same cycle.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.

## Structure

- Shared package `mips_pkg`:
  - loader state enum (IDLE, RECV, WRITE, CSUM);
  - `IMEM_DEPTH` = 2^ADDR_WIDTH;
  - `INSTR_WIDTH` = 32.
- One sub-module, `imem_word_packer`: byte shift register, 2-bit byte counter, running XOR, and a `word_full` flag.
- The FSM, word counter and output registers live in `imem_loader`.

## Test plan

- Reset, then `start` with len=2. Bytes 20 09 00 05 20 0A 00 0A, checksum 0C. Expect writes (0x0, 20090005) and (0x4, 200A000A), then `done` pulse, `error`=0, `cpu_rst` falling with `done`.
- Same stream with checksum 0D. Expect both writes, then `done` with `error`=1 and `cpu_rst` held at 1.
- Stream of len=3 with random `s_valid` gaps. Expect write contents and addresses identical to the gap-free run, with exactly one `mem_we` per word.
- `start` with `len_words`=0, and separately 257. Expect a `done` pulse, `error`=1, no `mem_we`, `s_ready` never 1.
- `rst` after 6 bytes of a len=2 load. Expect exactly one write (addr 0), then all reset values. A subsequent clean load succeeds.
- len=256 full load, with `start` pulsed mid-RECV. Expect the extra `start` ignored, the last write at 0x3FC, no wrap, and `error`=0.
